// File: rtl/act_unit_pipe.sv
// Two-stage, multi-lane activation unit: identity, PWL sigmoid/tanh, ReLU, leaky ReLU.
// Stage 1 captures |x|, sign, PWL segment and mode; stage 2 evaluates, clamps and flags saturation.
module act_unit_pipe #(
    parameter int unsigned W           = 16,
    parameter int unsigned FRAC        = 10,
    parameter int unsigned LANES       = 4,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   dout,
    output logic                 sat
);

    localparam int unsigned WI = W + 2;

    localparam logic [2:0] M_IDENT = 3'b000;
    localparam logic [2:0] M_SIG   = 3'b001;
    localparam logic [2:0] M_TANH  = 3'b010;
    localparam logic [2:0] M_RELU  = 3'b011;
    localparam logic [2:0] M_LEAKY = 3'b100;

    localparam logic signed [WI-1:0] ONE  = WI'(1 << FRAC);
    localparam logic signed [WI-1:0] C0   = WI'(1 << (FRAC - 1));
    localparam logic signed [WI-1:0] C1   = WI'(5 << (FRAC - 3));
    localparam logic signed [WI-1:0] C2   = WI'(27 << (FRAC - 5));
    localparam logic signed [WI-1:0] B1   = WI'(1 << FRAC);
    localparam logic signed [WI-1:0] B2   = WI'(19 << (FRAC - 3));
    localparam logic signed [WI-1:0] B3   = WI'(5 << FRAC);
    localparam logic signed [WI-1:0] MAXP = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [WI-1:0] MINN = {3'b111, {(W-1){1'b0}}};

    logic                 adv1;
    logic                 adv2;
    logic                 ld1;
    logic                 v1;
    logic [2:0]           mode1;
    logic [LANES*W-1:0]   dout_c;
    logic [LANES-1:0]     lane_sat;
    logic                 sat_c;

    // Handshake: a stage advances when its successor is empty or draining.
    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;
    assign ld1      = adv1 & in_valid;
    assign sat_c    = |lane_sat;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [WI-1:0] xe;
        logic signed [WI-1:0] t;
        logic signed [WI-1:0] a;
        logic                 ovf;
        logic                 neg;
        logic                 pre;
        logic [1:0]           seg;

        logic [W-1:0]         x1;
        logic signed [WI-1:0] a1;
        logic                 neg1;
        logic                 pre1;
        logic [1:0]           seg1;

        logic signed [WI-1:0] xs;
        logic signed [WI-1:0] f;
        logic signed [WI-1:0] sig;
        logic signed [WI-1:0] r;
        logic signed [WI-1:0] rc;
        logic                 rsv;
        logic                 clp;

        // Stage 1: tanh prescale by 2 (saturating), magnitude and PWL segment.
        always_comb begin
            xe  = WI'(signed'(z[g*W +: W]));
            t   = xe;
            ovf = 1'b0;
            if (mode == M_TANH) begin
                t = xe <<< 1;
                if (t > MAXP) begin
                    t   = MAXP;
                    ovf = 1'b1;
                end else if (t < MINN) begin
                    t   = MINN;
                    ovf = 1'b1;
                end
            end
            neg = t[WI-1];
            if (t == MINN) begin
                a   = MAXP;
                ovf = 1'b1;
            end else begin
                a = neg ? -t : t;
            end
            pre = ovf & ((mode == M_SIG) | (mode == M_TANH));
            if (a >= B3) begin
                seg = 2'd3;
            end else if (a >= B2) begin
                seg = 2'd2;
            end else if (a >= B1) begin
                seg = 2'd1;
            end else begin
                seg = 2'd0;
            end
        end

        always_ff @(posedge clk) begin
            if (ld1) begin
                x1   <= z[g*W +: W];
                a1   <= a;
                neg1 <= neg;
                pre1 <= pre;
                seg1 <= seg;
            end
        end

        // Stage 2: evaluate the beat's mode, then clamp to the signed W range.
        always_comb begin
            xs = WI'(signed'(x1));
            case (seg1)
                2'd3:    f = ONE;
                2'd2:    f = (a1 >>> 5) + C2;
                2'd1:    f = (a1 >>> 3) + C1;
                default: f = (a1 >>> 2) + C0;
            endcase
            sig = neg1 ? (ONE - f) : f;
            rsv = 1'b0;
            r   = '0;
            case (mode1)
                M_IDENT: r = xs;
                M_SIG:   r = sig;
                M_TANH:  r = (sig <<< 1) - ONE;
                M_RELU:  r = xs[WI-1] ? '0 : xs;
                M_LEAKY: r = xs[WI-1] ? (xs >>> LEAKY_SHIFT) : xs;
                default: begin
                    r   = '0;
                    rsv = 1'b1;
                end
            endcase
            rc  = r;
            clp = 1'b0;
            if (r > MAXP) begin
                rc  = MAXP;
                clp = 1'b1;
            end else if (r < MINN) begin
                rc  = MINN;
                clp = 1'b1;
            end
        end

        assign dout_c[g*W +: W] = rc[W-1:0];
        assign lane_sat[g]      = pre1 | clp | rsv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ld1) begin
            mode1 <= mode;
        end
    end

    // Output register holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                dout <= dout_c;
                sat  <= sat_c;
            end
        end
    end

endmodule
